// File: rtl/caliptra_prim_resp_router.sv
// Return-path router: tracks the grant index of each accepted request in an in-order FIFO
// and steers every returning response beat back to the requester that issued it.
module caliptra_prim_resp_router #(
    parameter int unsigned N     = 8,
    parameter int unsigned DW    = 32,
    parameter int unsigned Depth = 4,
    parameter int unsigned IdxW  = $clog2(N),
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_fire_i,
    input  logic [IdxW-1:0]     req_idx_i,
    output logic                req_stall_o,
    input  logic                rsp_valid_i,
    input  logic [DW-1:0]       rsp_data_i,
    output logic                rsp_ready_o,
    output logic [N-1:0]        rsp_valid_o,
    output logic [N*DW-1:0]     rsp_data_o,
    input  logic [N-1:0]        rsp_ready_i,
    output logic [CntW-1:0]     outstanding_o,
    output logic [2:0]          err_o
);

    localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [IdxW:0]   NumPorts = (IdxW + 1)'(N);

    logic [IdxW-1:0] mem_q [Depth];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [2:0]      err_q, err_d;

    logic            empty, full;
    logic [IdxW-1:0] head_idx;
    logic            head_ok;
    logic            push, pop, overflow, spurious, bad_idx;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == DepthCnt);
    assign head_idx = mem_q[head_q];
    assign head_ok  = ({1'b0, head_idx} < NumPorts);
    assign bad_idx  = ({1'b0, req_idx_i} >= NumPorts);

    // Routing looks only at the registered head, so a push never bypasses into the same cycle.
    always_comb begin
        rsp_valid_o = '0;
        rsp_ready_o = 1'b1;
        if (!empty && head_ok) begin
            for (int i = 0; i < N; i++) begin
                if (head_idx == IdxW'(i)) begin
                    rsp_valid_o[i] = rsp_valid_i;
                    rsp_ready_o    = rsp_ready_i[i];
                end
            end
        end
    end

    assign rsp_data_o = {N{rsp_data_i}};

    assign pop      = rsp_valid_i & rsp_ready_o & ~empty;
    assign spurious = rsp_valid_i & empty;
    assign push     = req_fire_i & (~full | pop);
    assign overflow = req_fire_i & full & ~pop;

    always_comb begin
        head_d  = pop  ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
        err_d = err_q | {req_fire_i & bad_idx, overflow, spurious};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Tracker storage holds no control state, so it is left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_q] <= req_idx_i;
        end
    end

    assign req_stall_o   = full;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    a_onehot_valid: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid_o));
    a_count_bound:  assert property (@(posedge clk_i) disable iff (rst_i) count_q <= DepthCnt);
    a_known_out:    assert property (@(posedge clk_i) disable iff (rst_i)
                        !$isunknown({rsp_valid_o, rsp_ready_o, req_stall_o, outstanding_o}));

endmodule

// File: tb/tb_caliptra_prim_resp_router.sv
// Scoreboard bench for caliptra_prim_resp_router: an N=8 instance for routing, stall, hold,
// spurious and reset cases, and an N=5 instance for out-of-range index sinking.
module tb_caliptra_prim_resp_router;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_fire = 1'b0;
    logic [2:0]   a_idx = '0;
    logic         a_stall;
    logic         a_rv_i = 1'b0;
    logic [31:0]  a_rd_i = '0;
    logic         a_rr_o;
    logic [7:0]   a_rv_o;
    logic [255:0] a_rd_o;
    logic [7:0]   a_rr_i = '0;
    logic [2:0]   a_out;
    logic [2:0]   a_err;

    logic         b_fire = 1'b0;
    logic [2:0]   b_idx = '0;
    logic         b_stall;
    logic         b_rv_i = 1'b0;
    logic [31:0]  b_rd_i = '0;
    logic         b_rr_o;
    logic [4:0]   b_rv_o;
    logic [159:0] b_rd_o;
    logic [4:0]   b_rr_i = '0;
    logic [2:0]   b_out;
    logic [2:0]   b_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t qa[$];
    exp_t qb[$];

    caliptra_prim_resp_router #(.N(8), .DW(32), .Depth(4)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_fire_i(a_fire), .req_idx_i(a_idx), .req_stall_o(a_stall),
        .rsp_valid_i(a_rv_i), .rsp_data_i(a_rd_i), .rsp_ready_o(a_rr_o),
        .rsp_valid_o(a_rv_o), .rsp_data_o(a_rd_o), .rsp_ready_i(a_rr_i),
        .outstanding_o(a_out), .err_o(a_err)
    );

    caliptra_prim_resp_router #(.N(5), .DW(32), .Depth(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_fire_i(b_fire), .req_idx_i(b_idx), .req_stall_o(b_stall),
        .rsp_valid_i(b_rv_i), .rsp_data_i(b_rd_i), .rsp_ready_o(b_rr_o),
        .rsp_valid_o(b_rv_o), .rsp_data_o(b_rd_o), .rsp_ready_i(b_rr_i),
        .outstanding_o(b_out), .err_o(b_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every accepted response beat must match the next scoreboard entry.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && a_rv_i && a_rr_o) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_beat: got rsp_valid_o=0x%0h, expected no beat", a_rv_o);
            end else begin
                e = qa.pop_front();
                check("a_route_vld", {24'b0, a_rv_o}, (e.idx < 0) ? 32'd0 : (32'd1 << e.idx));
                if (e.idx >= 0) check("a_route_data", a_rd_o[e.idx*32 +: 32], e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && b_rv_i && b_rr_o) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_beat: got rsp_valid_o=0x%0h, expected no beat", b_rv_o);
            end else begin
                e = qb.pop_front();
                check("b_route_vld", {27'b0, b_rv_o}, (e.idx < 0) ? 32'd0 : (32'd1 << e.idx));
                if (e.idx >= 0) check("b_route_data", b_rd_o[e.idx*32 +: 32], e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rsp_a(input int idx, input logic [31:0] data);
        qa.push_back('{idx, data});
        a_rv_i = 1'b1;
        a_rd_i = data;
        tick();
        a_rv_i = 1'b0;
    endtask

    task automatic rsp_b(input int idx, input logic [31:0] data);
        qb.push_back('{idx, data});
        b_rv_i = 1'b1;
        b_rd_i = data;
        tick();
        b_rv_i = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_outstanding", a_out, 0);
        check("rst_stall", a_stall, 0);
        check("rst_valid_o", a_rv_o, 0);
        check("rst_err", a_err, 0);
        check("rst_ready_o", a_rr_o, 1);
        tick();
        rst = 1'b0;

        // In-order routing of three responses
        a_rr_i = 8'hFF;
        a_fire = 1'b1; a_idx = 3'd3; tick();
        a_idx = 3'd0; tick();
        a_idx = 3'd7; tick();
        a_fire = 1'b0;
        @(negedge clk);
        check("t1_outstanding3", a_out, 3);
        tick();
        rsp_a(3, 32'hA000_0003);
        rsp_a(0, 32'hA000_0000);
        rsp_a(7, 32'hA000_0007);
        @(negedge clk);
        check("t1_outstanding0", a_out, 0);
        check("t1_err", a_err, 0);
        tick();

        // Full tracker, overflow drop, push+pop while full
        pulse_rst();
        a_fire = 1'b1;
        a_idx = 3'd1; tick();
        a_idx = 3'd2; tick();
        a_idx = 3'd3; tick();
        a_idx = 3'd4; tick();
        a_idx = 3'd6;
        @(negedge clk);
        check("t2_full_count", a_out, 4);
        check("t2_stall", a_stall, 1);
        check("t2_err_pre", a_err, 0);
        tick();
        a_idx = 3'd5;
        qa.push_back('{1, 32'hB000_0001});
        a_rv_i = 1'b1; a_rd_i = 32'hB000_0001;
        @(negedge clk);
        check("t2_drop_count", a_out, 4);
        check("t2_overflow_err", a_err, 3'b010);
        tick();
        a_fire = 1'b0; a_rv_i = 1'b0;
        @(negedge clk);
        check("t2_pushpop_count", a_out, 4);
        check("t2_pushpop_err", a_err, 3'b010);
        check("t2_pushpop_stall", a_stall, 1);
        tick();
        rsp_a(2, 32'hB000_0002);
        rsp_a(3, 32'hB000_0003);
        rsp_a(4, 32'hB000_0004);
        rsp_a(5, 32'hB000_0005);
        @(negedge clk);
        check("t2_drain_count", a_out, 0);
        check("t2_drain_stall", a_stall, 0);
        tick();

        // Back-pressure holds the routed port
        pulse_rst();
        a_fire = 1'b1; a_idx = 3'd5; tick();
        a_fire = 1'b0;
        a_rr_i = 8'hDF;
        a_rv_i = 1'b1; a_rd_i = 32'hC000_0005;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_ready", a_rr_o, 0);
            check("t3_hold_valid", a_rv_o, 8'h20);
            check("t3_hold_count", a_out, 1);
            tick();
        end
        qa.push_back('{5, 32'hC000_0005});
        a_rr_i = 8'hFF;
        @(negedge clk);
        check("t3_release_ready", a_rr_o, 1);
        tick();
        a_rv_i = 1'b0;
        @(negedge clk);
        check("t3_popped", a_out, 0);
        tick();

        // Spurious response on an empty tracker
        pulse_rst();
        qa.push_back('{-1, 32'hD000_0000});
        a_rv_i = 1'b1; a_rd_i = 32'hD000_0000;
        @(negedge clk);
        check("t4_ready", a_rr_o, 1);
        check("t4_valid_o", a_rv_o, 0);
        check("t4_err_pre", a_err, 0);
        tick();
        a_rv_i = 1'b0;
        @(negedge clk);
        check("t4_err_set", a_err, 3'b001);
        check("t4_count", a_out, 0);
        tick();
        tick();
        @(negedge clk);
        check("t4_err_sticky", a_err, 3'b001);
        tick();

        // Reset with three entries outstanding
        a_rr_i = 8'h00;
        a_fire = 1'b1; a_idx = 3'd3; tick();
        a_idx = 3'd4; tick();
        a_idx = 3'd7; tick();
        a_fire = 1'b0;
        a_rv_i = 1'b1; a_rd_i = 32'hE000_0003;
        @(negedge clk);
        check("t6_pre_count", a_out, 3);
        check("t6_pre_valid", a_rv_o, 8'h08);
        check("t6_pre_err", a_err, 3'b001);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_count", a_out, 0);
        check("t6_rst_valid", a_rv_o, 0);
        check("t6_rst_err", a_err, 0);
        check("t6_rst_stall", a_stall, 0);
        a_rv_i = 1'b0;
        tick();
        rst = 1'b0;
        a_rr_i = 8'hFF;

        // Out-of-range index on a 5-port instance
        b_rr_i = 5'h1F;
        b_fire = 1'b1; b_idx = 3'd6; tick();
        b_idx = 3'd2; tick();
        b_fire = 1'b0;
        @(negedge clk);
        check("t5_err_badidx", b_err, 3'b100);
        check("t5_count2", b_out, 2);
        tick();
        rsp_b(-1, 32'hF000_0006);
        rsp_b(2, 32'hF000_0002);
        @(negedge clk);
        check("t5_count0", b_out, 0);
        check("t5_err_final", b_err, 3'b100);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
